riscv_mc_controller: RTL

- Multi-cycle control FSM for the RV32I datapath. Decodes the latched instruction fields and sequences the datapath mux selects and write enables.
- Drives the 4-bit ALU opcode. Consumes the ALU zero/neg flags to resolve branches.
- Sits between the instruction register and the datapath. One instruction is in flight at a time.

---
 rtl/riscv_mc_controller.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I control FSM: decodes IR fields and sequences the datapath
// mux selects, ALU opcode and write enables, one instruction in flight.
//
// state      | meaning
// -----------+----------------------------------------------
// FETCH    0 | read instr at PC, latch IR/OldPC, PC <= PC+4
// DECODE   1 | dispatch on op, precompute OldPC+imm (branch)
// MEMADR   2 | address = RD1 + imm for lw/sw
// MEMREAD  3 | read data memory at computed address
// MEMWB    4 | write loaded data to rd
// MEMWRITE 5 | store RD2 at computed address
// EXECR    6 | RD1 op RD2
// EXECI    7 | RD1 op imm
// ALUWB    8 | write ALUOut to rd
// BRANCH   9 | compare RD1-RD2, redirect PC when taken
// JAL     10 | PC <= target, ALU computes OldPC+4 for the link
// JALRADR 11 | target = RD1 + imm
// LUI     12 | write ImmExt (U) to rd
module riscv_mc_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       zero,
   input  logic       neg,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [3:0] alu_control,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] imm_src,
   output logic       reg_write,
   output logic       instr_done,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALRADR  = 4'd11,
      S_LUI      = 4'd12
   } state_t;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   state_t state_q, state_d;

   logic pc_update;
   logic branch;
   logic taken;
   logic [3:0] alu_dec;
   logic op_legal;

   logic unused_funct7;
   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   assign state = state_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      op_legal = 1'b0;
      case (op)
         OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI: op_legal = 1'b1;
         default: op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BR:        state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
               OP_JALR:      state_d = S_JALRADR;
               OP_LUI:       state_d = S_LUI;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECR,
         S_EXECI:    state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_JALRADR:  state_d = S_JAL;
         default:    state_d = S_FETCH;
      endcase
   end

   // funct7[5] selects SUB only for register-register ops
   always_comb begin
      alu_dec = ALU_ADD;
      case (funct3)
         3'b000:  alu_dec = (state_q == S_EXECR && funct7[5]) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_dec = ALU_SLT;
         3'b011:  alu_dec = ALU_SLTU;
         3'b100:  alu_dec = ALU_XOR;
         3'b110:  alu_dec = ALU_OR;
         3'b111:  alu_dec = ALU_AND;
         default: alu_dec = ALU_ADD;
      endcase
   end

   // neg is raw ALU result[31]; signed overflow is not corrected
   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = neg;
         3'b101:  taken = ~neg;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      result_src  = 2'b00;
      alu_control = ALU_AND;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      imm_src     = 3'b000;
      reg_write   = 1'b0;
      instr_done  = 1'b0;
      pc_update   = 1'b0;
      branch      = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write    = 1'b1;
            alu_src_b   = 2'b10;
            alu_control = ALU_ADD;
            result_src  = 2'b10;
            pc_update   = 1'b1;
         end
         S_DECODE: begin
            alu_src_a   = 2'b01;
            alu_src_b   = 2'b01;
            imm_src     = 3'b010;
            alu_control = ALU_ADD;
            instr_done  = ~op_legal;
         end
         S_MEMADR: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = ALU_ADD;
            imm_src     = (op == OP_SW) ? 3'b001 : 3'b000;
         end
         S_MEMREAD: begin
            adr_src     = 1'b1;
         end
         S_MEMWB: begin
            result_src  = 2'b01;
            reg_write   = 1'b1;
            instr_done  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src     = 1'b1;
            mem_write   = 1'b1;
            instr_done  = 1'b1;
         end
         S_EXECR: begin
            alu_src_a   = 2'b10;
            alu_control = alu_dec;
         end
         S_EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = alu_dec;
         end
         S_ALUWB: begin
            reg_write   = 1'b1;
            instr_done  = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a   = 2'b10;
            alu_control = ALU_SUB;
            branch      = 1'b1;
            instr_done  = 1'b1;
         end
         S_JAL: begin
            alu_src_a   = 2'b01;
            alu_src_b   = 2'b10;
            alu_control = ALU_ADD;
            pc_update   = 1'b1;
         end
         S_JALRADR: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = ALU_ADD;
         end
         S_LUI: begin
            imm_src     = 3'b100;
            result_src  = 2'b11;
            reg_write   = 1'b1;
            instr_done  = 1'b1;
         end
         default: ;
      endcase
      // no write enable may leak out while reset is held
      if (rst) begin
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         instr_done = 1'b0;
         pc_update  = 1'b0;
         branch     = 1'b0;
      end
   end

   assign pc_write = pc_update | (branch & taken);

endmodule
